sccb_config_sequencer: RTL and testbench

//  Walks a register-initialisation table (camera sensor over SCCB) and issues one write per entry
//  to an SCCB master through a valid/ready + done handshake. Generalised table width and depth;

---
 rtl/sccb_cfg_pkg.sv | 41 ++++
 rtl/cfg_delay_timer.sv | 39 +++
 rtl/sccb_config_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_cfg_pkg.sv
// Shared types and table-entry helpers for the SCCB configuration sequencer.
// Entries are passed zero-extended to 64 bits together with their real width,
// so the helpers serve any REG_W/VAL_W combination up to 64 bits in total.
package sccb_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_WAIT_ROM = 4'd2,
        ST_DECODE   = 4'd3,
        ST_WRITE    = 4'd4,
        ST_WAIT_ACK = 4'd5,
        ST_DELAY    = 4'd6,
        ST_NEXT     = 4'd7,
        ST_DONE     = 4'd8,
        ST_ERROR    = 4'd9
    } seq_state_t;

    // Width of the delay-length field in the low bits of a DELAY marker.
    localparam int unsigned DELAY_N_W = 4;

    // END marker: every bit of the entry is one.
    function automatic logic is_end_marker(input logic [63:0] entry, input int unsigned entry_w);
        logic [63:0] mask;
        mask = (64'd1 << entry_w) - 64'd1;
        return (entry & mask) == mask;
    endfunction

    // DELAY marker: all ones above the delay field. END also matches, so decode END first.
    function automatic logic is_delay_marker(input logic [63:0] entry, input int unsigned entry_w);
        logic [63:0] mask;
        mask = ((64'd1 << entry_w) - 64'd1) & ~64'hF;
        return (entry & mask) == mask;
    endfunction

    // Delay length n of a DELAY marker; the wait lasts n+1 units.
    function automatic logic [DELAY_N_W-1:0] delay_units(input logic [63:0] entry);
        return entry[DELAY_N_W-1:0];
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Delay timer for DELAY markers: a load of n arms a single down-counter for
// (n+1)*DELAY_UNIT cycles; expired is high once the counter has reached zero.
module cfg_delay_timer
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned DELAY_UNIT = 250000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DELAY_N_W-1:0] units,
    output logic                 expired
);

    localparam int unsigned CNT_W = $clog2(16 * DELAY_UNIT);
    localparam logic [CNT_W-1:0] UNIT_C = CNT_W'(DELAY_UNIT);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] load_val_s;

    // Load value counts down to zero, so one less than the total wait.
    assign load_val_s = (CNT_W'(units) + CNT_W'(1)) * UNIT_C - CNT_W'(1);

    // Down-counter: reload on request, otherwise count to zero and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val_s;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == '0);

endmodule

// File: rtl/sccb_config_sequencer.sv
// Walks the camera register-init table and issues one SCCB write per entry.
// Optional build macro CFG_SEQ_RETRY_EN: a NACKed write is re-issued up to
// MAX_RETRY times before the sequence stops in ERROR; without it the first
// NACK stops the sequence.
module sccb_config_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned REG_W      = 8,
    parameter int unsigned VAL_W      = 8,
    parameter int unsigned DELAY_UNIT = 250000,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [REG_W+VAL_W-1:0] rom_data,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [REG_W-1:0]       wr_reg,
    output logic [VAL_W-1:0]       wr_val,
    input  logic                   wr_done,
    input  logic                   wr_nack,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_W-1:0]      entry_idx
);

    localparam int unsigned ENTRY_W = REG_W + VAL_W;
    localparam logic [ADDR_W-1:0] IDX_LAST = '1;

    seq_state_t        state_r, state_s;
    logic [ADDR_W-1:0] idx_r;
    logic [REG_W-1:0]  wr_reg_r;
    logic [VAL_W-1:0]  wr_val_r;
    logic              wr_valid_r, busy_r, done_r, error_r;
    logic              entry_end_s, entry_delay_s;
    logic              timer_load_s, timer_expired_s;
    logic              retry_ok_s;

    assign entry_end_s   = is_end_marker(64'(rom_data), ENTRY_W);
    assign entry_delay_s = is_delay_marker(64'(rom_data), ENTRY_W);

    cfg_delay_timer #(
        .DELAY_UNIT (DELAY_UNIT)
    ) u_delay_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load_s),
        .units   (delay_units(64'(rom_data))),
        .expired (timer_expired_s)
    );

`ifdef CFG_SEQ_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_r;

    assign retry_ok_s = (retry_r < RETRY_W'(MAX_RETRY));

    // Retries spent on the current entry; cleared whenever a new entry is decoded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_r <= '0;
        end else if (state_r == ST_DECODE) begin
            retry_r <= '0;
        end else if ((state_r == ST_WAIT_ACK) && wr_done && wr_nack && retry_ok_s) begin
            retry_r <= retry_r + RETRY_W'(1);
        end else begin
            retry_r <= retry_r;
        end
    end
`else
    assign retry_ok_s = 1'b0;
`endif

    // Next-state decode and delay-timer load.
    always_comb begin
        state_s      = state_r;
        timer_load_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_s = ST_FETCH;
                else       state_s = state_r;
            end
            ST_FETCH:    state_s = ST_WAIT_ROM;
            ST_WAIT_ROM: state_s = ST_DECODE;
            ST_DECODE: begin
                if (entry_end_s) begin
                    state_s = ST_DONE;
                end else if (entry_delay_s) begin
                    state_s      = ST_DELAY;
                    timer_load_s = 1'b1;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            // wr_valid is high for exactly the cycles spent here.
            ST_WRITE: begin
                if (wr_ready) state_s = ST_WAIT_ACK;
                else          state_s = ST_WRITE;
            end
            ST_WAIT_ACK: begin
                if (!wr_done)        state_s = ST_WAIT_ACK;
                else if (!wr_nack)   state_s = ST_NEXT;
                else if (retry_ok_s) state_s = ST_WRITE;
                else                 state_s = ST_ERROR;
            end
            ST_DELAY: begin
                if (timer_expired_s) state_s = ST_NEXT;
                else                 state_s = ST_DELAY;
            end
            // No wrap: the last slot ends the sequence even without an END marker.
            ST_NEXT: begin
                if (idx_r == IDX_LAST) state_s = ST_DONE;
                else                   state_s = ST_FETCH;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Table index: zero on a fresh start, advance on NEXT, hold otherwise (holds failing index).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= '0;
        end else if ((state_s == ST_FETCH) && (state_r != ST_NEXT)) begin
            idx_r <= '0;
        end else if ((state_s == ST_FETCH) && (state_r == ST_NEXT)) begin
            idx_r <= idx_r + ADDR_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Capture the write payload at decode so it stays stable through handshake and retries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_reg_r <= '0;
            wr_val_r <= '0;
        end else if ((state_r == ST_DECODE) && (state_s == ST_WRITE)) begin
            wr_reg_r <= rom_data[ENTRY_W-1:VAL_W];
            wr_val_r <= rom_data[VAL_W-1:0];
        end else begin
            wr_reg_r <= wr_reg_r;
            wr_val_r <= wr_val_r;
        end
    end

    // Registered handshake and status flags, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            wr_valid_r <= (state_s == ST_WRITE);
            busy_r     <= !((state_s == ST_IDLE) || (state_s == ST_DONE) || (state_s == ST_ERROR));
            done_r     <= (state_s == ST_DONE);
            error_r    <= (state_s == ST_ERROR);
        end
    end

    assign rom_addr  = idx_r;
    assign entry_idx = idx_r;
    assign wr_valid  = wr_valid_r;
    assign wr_reg    = wr_reg_r;
    assign wr_val    = wr_val_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Directed bench for sccb_config_sequencer (ADDR_W=3, DELAY_UNIT=10).
// A behavioural ROM and SCCB master respond to the DUT; expected values are hand-computed.
module tb_sccb_config_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  rom_addr;
    logic [15:0] rom_data;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [7:0]  wr_reg;
    logic [7:0]  wr_val;
    logic        wr_done = 1'b0;
    logic        wr_nack = 1'b0;
    logic        busy, done, error;
    logic [2:0]  entry_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sccb_config_sequencer #(
        .ADDR_W     (3),
        .REG_W      (8),
        .VAL_W      (8),
        .DELAY_UNIT (10),
        .MAX_RETRY  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_reg    (wr_reg),
        .wr_val    (wr_val),
        .wr_done   (wr_done),
        .wr_nack   (wr_nack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .entry_idx (entry_idx)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Synchronous table ROM.
    logic [15:0] rom [8];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB master model: optional stall, accept, wr_done 3 cycles after accept.
    int          stall_cycles = 0;
    int          stall_hits   = 0;
    logic [15:0] stall_exp    = 16'h0000;
    int          done_cnt     = 0;
    logic        pend_nack    = 1'b0;
    int          nack_idx     = -1;
    int          nack_left    = 0;
    logic [15:0] log_q [$];

    initial begin
        forever begin
            @(negedge clk);
            wr_done  = 1'b0;
            wr_nack  = 1'b0;
            wr_ready = 1'b0;
            if (!rst_n) begin
                done_cnt = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        wr_done = 1'b1;
                        wr_nack = pend_nack;
                    end
                end
                if (wr_valid) begin
                    if (stall_cycles > 0) begin
                        stall_cycles--;
                        stall_hits++;
                        check("stall_reg", wr_reg, stall_exp[15:8]);
                        check("stall_val", wr_val, stall_exp[7:0]);
                    end else begin
                        wr_ready = 1'b1;
                        log_q.push_back({wr_reg, wr_val});
                        pend_nack = (int'(entry_idx) == nack_idx) && (nack_left > 0);
                        if (pend_nack) nack_left--;
                        done_cnt = 3;
                    end
                end
            end
        end
    end

    // rom_addr monitor: cycle at which each index appears, and any 7->0 wrap while busy.
    int         cyc = 0;
    logic [2:0] prev_addr = 3'd0;
    int         chg_t [8];
    logic       wrap_seen = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rom_addr != prev_addr) begin
                chg_t[rom_addr] = cyc;
                if (prev_addr == 3'd7 && rom_addr == 3'd0 && busy) wrap_seen = 1'b1;
                prev_addr = rom_addr;
            end
        end
    end

    task automatic load_table(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                              input logic [15:0] e3, input logic [15:0] e4);
        for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3; rom[4] = e4;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int exp_nack_writes, exp_retry_writes, exp_retry_nacks, n;
`ifdef CFG_SEQ_RETRY_EN
        exp_nack_writes  = 6;  // entries 0,1 then entry 2 issued 1+3 times
        exp_retry_nacks  = 2;
        exp_retry_writes = 6;  // 0,1, entry 2 three times, 3
`else
        exp_nack_writes  = 3;
        exp_retry_nacks  = 0;
        exp_retry_writes = 4;
`endif
        load_table(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_rom_addr", rom_addr, 3'd0);
        check("rst_entry_idx", entry_idx, 3'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: writes around a one-unit delay, start-to-wr_valid latency of 4
        load_table(16'h1280, 16'hFFF0, 16'h1210, 16'hFFFF, 16'hFFFF);
        log_q.delete();
        pulse_start();
        check("t1_lat1", wr_valid, 1'b0);
        @(negedge clk); check("t1_lat2", wr_valid, 1'b0);
        @(negedge clk); check("t1_lat3", wr_valid, 1'b0);
        @(negedge clk); check("t1_lat4", wr_valid, 1'b1);
        wait_idle("t1", 300);
        check("t1_nwr", log_q.size(), 2);
        check("t1_wr0", log_q[0], 16'h1280);
        check("t1_wr1", log_q[1], 16'h1210);
        check("t1_done", done, 1'b1);
        check("t1_error", error, 1'b0);
        check("t1_idx", entry_idx, 3'd3);
        check("t1_delay_dwell", chg_t[2] - chg_t[1], 14);

        // 2: four-unit delay occupies 40 cycles; restart from DONE clears done
        load_table(16'hFFF3, 16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        log_q.delete();
        pulse_start();
        check("t2_done_clr", done, 1'b0);
        check("t2_busy", busy, 1'b1);
        wait_idle("t2", 300);
        check("t2_delay_dwell", chg_t[1] - chg_t[0], 44);
        check("t2_nwr", log_q.size(), 1);
        check("t2_wr0", log_q[0], 16'h1234);
        check("t2_done", done, 1'b1);
        check("t2_idx", entry_idx, 3'd2);

        // 3: master stalls 7 cycles; request stays stable, single accept
        load_table(16'h5566, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        log_q.delete();
        stall_hits   = 0;
        stall_exp    = 16'h5566;
        stall_cycles = 7;
        pulse_start();
        wait_idle("t3", 300);
        check("t3_stall_hits", stall_hits, 7);
        check("t3_nwr", log_q.size(), 1);
        check("t3_wr0", log_q[0], 16'h5566);
        check("t3_done", done, 1'b1);

        // 4: persistent NACK on entry 2
        load_table(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'hFFFF);
        log_q.delete();
        nack_idx  = 2;
        nack_left = 100;
        pulse_start();
        wait_idle("t4a", 500);
        check("t4a_nwr", log_q.size(), exp_nack_writes);
        check("t4a_error", error, 1'b1);
        check("t4a_done", done, 1'b0);
        check("t4a_idx", entry_idx, 3'd2);
        // 4b: restart from ERROR, entry 2 NACKed only a bounded number of times
        log_q.delete();
        nack_left = exp_retry_nacks;
        pulse_start();
        check("t4b_err_clr", error, 1'b0);
        wait_idle("t4b", 500);
        check("t4b_nwr", log_q.size(), exp_retry_writes);
        check("t4b_done", done, 1'b1);
        check("t4b_error", error, 1'b0);
        check("t4b_idx", entry_idx, 3'd4);
        nack_idx  = -1;
        nack_left = 0;

        // 5: full table without END; ignores a start while busy; no wrap
        for (int i = 0; i < 8; i++) rom[i] = 16'h1000 + 16'(i);
        log_q.delete();
        wrap_seen = 1'b0;
        pulse_start();
        repeat (20) @(negedge clk);
        check("t5_busy_mid", busy, 1'b1);
        pulse_start();
        wait_idle("t5", 600);
        check("t5_nwr", log_q.size(), 8);
        check("t5_wr0", log_q[0], 16'h1000);
        check("t5_wr7", log_q[7], 16'h1007);
        check("t5_done", done, 1'b1);
        check("t5_idx", entry_idx, 3'd7);
        check("t5_rom_addr", rom_addr, 3'd7);
        check("t5_no_wrap", wrap_seen, 1'b0);

        // 6: async reset while a write is pending
        load_table(16'h7788, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        log_q.delete();
        stall_exp    = 16'h7788;
        stall_cycles = 100;
        pulse_start();
        n = 0;
        while (!wr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_valid_up", wr_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", wr_valid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_idx", entry_idx, 3'd0);
        stall_cycles = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_busy", busy, 1'b0);
        check("t6_no_accept", log_q.size(), 0);
        pulse_start();
        wait_idle("t6a", 300);
        check("t6a_nwr", log_q.size(), 1);
        check("t6a_wr0", log_q[0], 16'h7788);
        check("t6a_done", done, 1'b1);
        pulse_start();
        check("t6b_done_clr", done, 1'b0);
        check("t6b_addr0", rom_addr, 3'd0);
        wait_idle("t6b", 300);
        check("t6b_nwr", log_q.size(), 2);
        check("t6b_done", done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
